read_scheduler: RTL

- Output-side counterpart of the write arbiter in the SRAM controller.
- Each output port has NUM_QUEUES priority queues in shared SRAM. This block picks which queue's head packet the SRAM read engine dequeues next.
- Selection uses strict priority (SP) or weighted round robin (WRR).
- Scheduling is non-preemptive at packet granularity, with a valid/ready request handshake and a packet-completion return.

---
 rtl/read_scheduler_pkg.sv | 27 ++
 rtl/read_scheduler_if.sv | 31 +++
 rtl/read_scheduler_wrr_pick.sv | 59 +++++
 rtl/read_scheduler.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/read_scheduler_pkg.sv
// read_scheduler_pkg
//   Shared definitions for the output-side read scheduler: FSM state encoding,
//   default sizing, queue-index width derivation and the scheduling-mode
//   constants (the write arbiter uses the same mode encoding).
package read_scheduler_pkg;

    localparam int NUM_QUEUES_DEF = 8;
    localparam int WEIGHT_W_DEF   = 4;

    // Queue index width; at least one bit even for a single queue.
    function automatic int qid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int QID_W_DEF = qid_width(NUM_QUEUES_DEF);

    // sp0_wrr1 encoding
    localparam logic MODE_SP  = 1'b0;
    localparam logic MODE_WRR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2
    } sched_state_e;

endpackage

// File: rtl/read_scheduler_if.sv
// read_scheduler_if
//   Request/completion bus between the read scheduler and the SRAM read engine.
//     rd_valid  scheduler -> engine  read request valid
//     rd_queue  scheduler -> engine  queue whose head packet is to be read
//     rd_ready  engine -> scheduler  request accepted
//     pkt_done  engine -> scheduler  one-cycle pulse, current packet finished
//   master = scheduler side, slave = read engine side.
interface read_scheduler_if
    import read_scheduler_pkg::*;
#(
    parameter int QID_W = QID_W_DEF
);
    logic             rd_valid;
    logic [QID_W-1:0] rd_queue;
    logic             rd_ready;
    logic             pkt_done;

    modport master (
        output rd_valid,
        output rd_queue,
        input  rd_ready,
        input  pkt_done
    );

    modport slave (
        input  rd_valid,
        input  rd_queue,
        output rd_ready,
        output pkt_done
    );
endinterface

// File: rtl/read_scheduler_wrr_pick.sv
// read_scheduler_wrr_pick
//   Combinational rotating first-match search for weighted round robin.
//     mask     queues holding a complete packet
//     credits  per-queue remaining credit (packed, queue j at index j)
//     ptr      queue where the search starts
//     found    some nonempty queue still has credit; index points at it
//     reload   queues are nonempty but none has credit; index points at the
//              first nonempty queue from ptr (credits get refilled by caller)
//     index    selected queue
module read_scheduler_wrr_pick #(
    parameter int NUM_QUEUES = 8,
    parameter int WEIGHT_W   = 4,
    parameter int QID_W      = 3
) (
    input  logic [NUM_QUEUES-1:0]               mask,
    input  logic [NUM_QUEUES-1:0][WEIGHT_W-1:0] credits,
    input  logic [QID_W-1:0]                    ptr,
    output logic                                found,
    output logic                                reload,
    output logic [QID_W-1:0]                    index
);

    logic [NUM_QUEUES-1:0] credit_nz;
    logic [NUM_QUEUES-1:0] eligible;
    logic [NUM_QUEUES-1:0] search;
    logic [QID_W:0]        pos;
    logic                  hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_QUEUES; gi++) begin : g_nz
            assign credit_nz[gi] = |credits[gi];
        end
    endgenerate

    assign eligible = mask & credit_nz;
    assign found    = |eligible;
    assign reload   = (|mask) && !found;
    // After a reload every credit is nonzero, so the first nonempty queue wins.
    assign search   = found ? eligible : mask;

    always_comb begin
        index = '0;
        hit   = 1'b0;
        pos   = '0;
        for (int k = 0; k < NUM_QUEUES; k++) begin
            pos = {1'b0, ptr} + (QID_W+1)'(k);
            // Explicit wrap so non-power-of-two queue counts work.
            if (pos >= (QID_W+1)'(NUM_QUEUES)) begin
                pos = pos - (QID_W+1)'(NUM_QUEUES);
            end
            if (!hit && search[pos[QID_W-1:0]]) begin
                hit   = 1'b1;
                index = pos[QID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/read_scheduler.sv
// read_scheduler
//   Picks which priority queue's head packet the SRAM read engine dequeues
//   next, by strict priority (highest index wins) or weighted round robin.
//   Non-preemptive: one request, then wait for the packet to complete.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     sp0_wrr1      0 = strict priority, 1 = weighted round robin
//     q_nonempty    bit j: queue j holds a complete packet
//     wrr_weights   packed weights, queue j at [(j+1)*WEIGHT_W-1 : j*WEIGHT_W]
//     sched_busy    request outstanding or packet in progress
//     rd_bus        request/completion bus (master side)
module read_scheduler
    import read_scheduler_pkg::*;
#(
    parameter int NUM_QUEUES = NUM_QUEUES_DEF,
    parameter int WEIGHT_W   = WEIGHT_W_DEF,
    parameter int QID_W      = qid_width(NUM_QUEUES)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sp0_wrr1,
    input  logic [NUM_QUEUES-1:0]          q_nonempty,
    input  logic [NUM_QUEUES*WEIGHT_W-1:0] wrr_weights,
    output logic                           sched_busy,
    read_scheduler_if.master               rd_bus
);

    sched_state_e state_q, state_d;
    logic                                rd_valid_q, rd_valid_d;
    logic [QID_W-1:0]                    rd_queue_q, rd_queue_d;
    logic                                sched_busy_q, sched_busy_d;
    logic [QID_W-1:0]                    ptr_q, ptr_d;
    logic [NUM_QUEUES-1:0][WEIGHT_W-1:0] credit_q, credit_d;

    logic [NUM_QUEUES-1:0][WEIGHT_W-1:0] weight_eff;
    logic [NUM_QUEUES-1:0][WEIGHT_W-1:0] credit_base;
    logic [WEIGHT_W-1:0]                 credit_left;
    logic [QID_W-1:0]                    sp_idx;
    logic [QID_W-1:0]                    grant;
    logic                                pick_found;
    logic                                pick_reload;
    logic [QID_W-1:0]                    pick_idx;

    // A zero weight still earns one packet per round.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_QUEUES; gi++) begin : g_weight
            assign weight_eff[gi] = (wrr_weights[gi*WEIGHT_W +: WEIGHT_W] == '0)
                                  ? WEIGHT_W'(1)
                                  : wrr_weights[gi*WEIGHT_W +: WEIGHT_W];
        end
    endgenerate

    read_scheduler_wrr_pick #(
        .NUM_QUEUES (NUM_QUEUES),
        .WEIGHT_W   (WEIGHT_W),
        .QID_W      (QID_W)
    ) u_wrr_pick (
        .mask    (q_nonempty),
        .credits (credit_q),
        .ptr     (ptr_q),
        .found   (pick_found),
        .reload  (pick_reload),
        .index   (pick_idx)
    );

    // Strict priority: highest set index.
    always_comb begin
        sp_idx = '0;
        for (int j = 0; j < NUM_QUEUES; j++) begin
            if (q_nonempty[j]) sp_idx = QID_W'(j);
        end
    end

    always_comb begin
        state_d      = state_q;
        rd_valid_d   = rd_valid_q;
        rd_queue_d   = rd_queue_q;
        sched_busy_d = sched_busy_q;
        ptr_d        = ptr_q;
        credit_d     = credit_q;
        // Reload and decrement happen in the same decision cycle.
        credit_base  = pick_reload ? weight_eff : credit_q;
        credit_left  = '0;
        grant        = sp_idx;

        case (state_q)
            ST_IDLE: begin
                if (|q_nonempty) begin
                    if (sp0_wrr1 == MODE_WRR && (pick_found || pick_reload)) begin
                        grant           = pick_idx;
                        credit_left     = credit_base[grant] - WEIGHT_W'(1);
                        credit_d        = credit_base;
                        credit_d[grant] = credit_left;
                        // Stay on a queue until its credit runs out.
                        if (credit_left == '0) begin
                            ptr_d = (grant == QID_W'(NUM_QUEUES-1)) ? '0 : grant + QID_W'(1);
                        end else begin
                            ptr_d = grant;
                        end
                    end
                    rd_queue_d   = grant;
                    rd_valid_d   = 1'b1;
                    sched_busy_d = 1'b1;
                    state_d      = ST_REQ;
                end
            end
            ST_REQ: begin
                if (rd_bus.rd_ready) begin
                    rd_valid_d = 1'b0;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (rd_bus.pkt_done) begin
                    sched_busy_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                rd_valid_d   = 1'b0;
                sched_busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rd_valid_q   <= 1'b0;
            rd_queue_q   <= '0;
            sched_busy_q <= 1'b0;
            ptr_q        <= '0;
            credit_q     <= weight_eff;
        end else begin
            state_q      <= state_d;
            rd_valid_q   <= rd_valid_d;
            rd_queue_q   <= rd_queue_d;
            sched_busy_q <= sched_busy_d;
            ptr_q        <= ptr_d;
            credit_q     <= credit_d;
        end
    end

    assign rd_bus.rd_valid = rd_valid_q;
    assign rd_bus.rd_queue = rd_queue_q;
    assign sched_busy      = sched_busy_q;

endmodule
